// File: rtl/bool_pkg.sv
// Shared definitions for the dual-form boolean evaluator.
// Op codes, self-test states and counter width default.
package bool_pkg;

  localparam int ERR_W_DEF = 16;

  localparam logic [2:0] OP_NAND_NC = 3'd0;
  localparam logic [2:0] OP_NOR_OC  = 3'd1;
  localparam logic [2:0] OP_XOR3    = 3'd2;
  localparam logic [2:0] OP_MAJ     = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } st_e;

endpackage

// File: rtl/bool_dual_core.sv
// Combinational evaluator: each op computed in direct form (d)
// and in its De Morgan dual form (e); e[0] optionally inverted.
module bool_dual_core
  import bool_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             fault_inj,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e
);

  logic [WIDTH-1:0] e_raw;

  always_comb begin
    d     = '0;
    e_raw = '0;
    unique case (op)
      OP_NAND_NC: begin
        d     = (~a | ~b) & ~c;
        e_raw = ~((a & b) | c);
      end
      OP_NOR_OC: begin
        d     = (~a & ~b) | c;
        e_raw = ~((a | b) & ~c);
      end
      OP_XOR3: begin
        d     = a ^ b ^ c;
        e_raw = ~(~a ^ b ^ c);
      end
      OP_MAJ: begin
        d     = (a & b) | (a & c) | (b & c);
        e_raw = ~((~a | ~b) & (~a | ~c) & (~b | ~c));
      end
      default: begin
        d     = '0;
        e_raw = '0;
      end
    endcase
    e    = e_raw;
    e[0] = e_raw[0] ^ fault_inj;
  end

endmodule

// File: rtl/bool_dual_eval.sv
// Registered dual-form evaluator with valid/ready handshake and
// an exhaustive self-test sweep counting form mismatches.
module bool_dual_eval
  import bool_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             fault_inj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic             mis,
  input  logic             st_start,
  output logic             st_busy,
  output logic             st_done,
  output logic             st_pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int VW = 2 + 3 * WIDTH;

  st_e              st_q, st_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             ov_q;
  logic [WIDTH-1:0] d_q, e_q;
  logic             mis_q;

  logic [WIDTH-1:0] nd, ne, sd, se;
  logic             xfer;

  bool_dual_core #(.WIDTH(WIDTH)) u_norm (
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .fault_inj (fault_inj),
    .d         (nd),
    .e         (ne)
  );

  // Sweep vector layout: {op[1:0], a, b, c}, c in the LSBs
  bool_dual_core #(.WIDTH(WIDTH)) u_sweep (
    .op        ({1'b0, vec_q[VW-1 -: 2]}),
    .a         (vec_q[3*WIDTH-1 -: WIDTH]),
    .b         (vec_q[2*WIDTH-1 -: WIDTH]),
    .c         (vec_q[WIDTH-1:0]),
    .fault_inj (fault_inj),
    .d         (sd),
    .e         (se)
  );

  assign in_ready  = (st_q == ST_IDLE) & (~ov_q | out_ready);
  assign xfer      = in_valid & in_ready;
  assign out_valid = ov_q;
  assign d         = d_q;
  assign e         = e_q;
  assign mis       = mis_q;
  assign st_busy   = (st_q == ST_SWEEP);
  assign st_done   = (st_q == ST_DONE);
  assign st_pass   = pass_q;
  assign err_count = err_q;

  always_comb begin
    st_d   = st_q;
    vec_d  = vec_q;
    err_d  = err_q;
    pass_d = pass_q;
    unique case (st_q)
      ST_IDLE: begin
        if (st_start && !ov_q) begin
          st_d   = ST_SWEEP;
          vec_d  = '0;
          err_d  = '0;
          pass_d = 1'b0;
        end
      end
      ST_SWEEP: begin
        if ((sd != se) && (err_q != '1)) err_d = err_q + ERR_W'(1);
        vec_d = vec_q + VW'(1);
        // Verdict lands with the DONE pulse, so compute it from err_d
        if (vec_q == '1) begin
          st_d   = ST_DONE;
          pass_d = (err_d == '0);
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      vec_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      ov_q   <= 1'b0;
      d_q    <= '0;
      e_q    <= '0;
      mis_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      vec_q  <= vec_d;
      err_q  <= err_d;
      pass_q <= pass_d;
      ov_q   <= xfer | (ov_q & ~out_ready);
      if (xfer) begin
        d_q   <= nd;
        e_q   <= ne;
        mis_q <= |(nd ^ ne);
      end
    end
  end

endmodule

// File: tb/tb_bool_dual_eval.sv
// Randomized and directed bench for bool_dual_eval against a
// per-bit truth model and an exhaustive-sweep mismatch count.
module tb_bool_dual_eval;

  localparam int W  = 4;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a, b, c;
  logic          fault_inj;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  d, e;
  logic          mis;
  logic          st_start;
  logic          st_busy;
  logic          st_done;
  logic          st_pass;
  logic [EW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic         mis;
  } res_t;

  res_t exp_q[$];

  bool_dual_eval #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .fault_inj (fault_inj),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .e         (e),
    .mis       (mis),
    .st_start  (st_start),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_pass   (st_pass),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Truth of each op per bit position, from input counts
  function automatic logic bit_fn(int o, int x, int y, int z);
    int n;
    n = x + y + z;
    case (o)
      0: return (z == 0) && !(x == 1 && y == 1);
      1: return (z == 1) || (x == 0 && y == 0);
      2: return (n % 2) == 1;
      3: return n >= 2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic res_t model(int o, logic [W-1:0] x,
                                 logic [W-1:0] y, logic [W-1:0] z,
                                 logic f);
    res_t r;
    for (int i = 0; i < W; i++)
      r.d[i] = bit_fn(o, int'(x[i]), int'(y[i]), int'(z[i]));
    r.e    = r.d;
    r.e[0] = r.d[0] ^ f;
    r.mis  = f;
    return r;
  endfunction

  function automatic int sweep_errs(logic f);
    int n;
    res_t r;
    n = 0;
    for (int v = 0; v < (4 << (3 * W)); v++) begin
      r = model(v >> (3 * W), W'(v >> (2 * W)), W'(v >> W), W'(v), f);
      if (r.d != r.e) n++;
    end
    if (n > 65535) n = 65535;
    return n;
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    c         = '0;
    fault_inj = 1'b0;
    st_start  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    op        = 3'd2;
    a         = 4'hF;
    b         = 4'h3;
    c         = 4'h5;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1",
               out_valid, in_ready);
    end
    total++;
    if (err_count !== '0 || st_pass !== 1'b0 || st_busy !== 1'b0 ||
        st_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_st: err=%0d pass=%b busy=%b done=%b want 0",
               err_count, st_pass, st_busy, st_done);
    end
    total++;
    if (d !== '0 || e !== '0 || mis !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: d=%h e=%h mis=%b want 0", d, e, mis);
    end
    exp_q.delete();
  endtask

  task automatic test_op0_directed();
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op        = 3'd0;
    a         = 4'b1100;
    b         = 4'b1010;
    c         = 4'b0001;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || d !== 4'b0110 || e !== 4'b0110 ||
        mis !== 1'b0) begin
      bad++;
      $display("FAIL op0: ov=%b d=%b e=%b mis=%b want 1 0110 0110 0",
               out_valid, d, e, mis);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    res_t r1, r2, r3;
    r1 = model(3, 4'h6, 4'hA, 4'h3, 1'b0);
    r2 = model(1, 4'h9, 4'h4, 4'h2, 1'b0);
    r3 = model(2, 4'h7, 4'hE, 4'h1, 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    op = 3'd3; a = 4'h6; b = 4'hA; c = 4'h3;
    @(negedge clk);
    op = 3'd1; a = 4'h9; b = 4'h4; c = 4'h2;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          d !== r1.d || e !== r1.e) begin
        bad++;
        $display("FAIL bp_hold%0d: rdy=%b ov=%b d=%h e=%h want 0 1 %h %h",
                 k, in_ready, out_valid, d, e, r1.d, r1.e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    op = 3'd2; a = 4'h7; b = 4'hE; c = 4'h1;
    #1;
    total++;
    if (out_valid !== 1'b1 || d !== r2.d || e !== r2.e) begin
      bad++;
      $display("FAIL b2b_1: ov=%b d=%h e=%h want 1 %h %h",
               out_valid, d, e, r2.d, r2.e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || d !== r3.d || e !== r3.e) begin
      bad++;
      $display("FAIL b2b_2: ov=%b d=%h e=%h want 1 %h %h",
               out_valid, d, e, r3.d, r3.e);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    res_t r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      c         = W'($urandom);
      fault_inj = ($urandom_range(0, 7) == 0);
      #1;
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("FAIL rnd_ready: in_ready=%b ov=%b ordy=%b",
                 in_ready, out_valid, out_ready);
      end
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra: unexpected result d=%h e=%h", d, e);
        end else if (d !== exp_q[0].d || e !== exp_q[0].e ||
                     mis !== exp_q[0].mis) begin
          bad++;
          $display("FAIL rnd_data: d=%h e=%h mis=%b want %h %h %b",
                   d, e, mis, exp_q[0].d, exp_q[0].e, exp_q[0].mis);
        end
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        r = model(int'(op), a, b, c, fault_inj);
        exp_q.push_back(r);
      end
    end
    @(negedge clk);
    idle_inputs();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drain: ov=%b left=%0d want 0 0",
               out_valid, exp_q.size());
    end
  endtask

  task automatic run_sweep(input logic f, input string nm);
    int busy_n, done_n, want;
    logic pass_at_done;
    want = sweep_errs(f);
    busy_n = 0;
    done_n = 0;
    pass_at_done = 1'b0;
    @(negedge clk);
    fault_inj = f;
    st_start  = 1'b1;
    @(negedge clk);
    st_start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      #1;
      if (st_busy) busy_n++;
      if (st_done) begin
        done_n++;
        pass_at_done = st_pass;
      end
      if (!st_busy && !st_done && busy_n > 0) break;
      @(negedge clk);
    end
    total++;
    if (busy_n != 16384 || done_n != 1) begin
      bad++;
      $display("FAIL %s_len: busy=%0d done=%0d want 16384 1",
               nm, busy_n, done_n);
    end
    total++;
    if (err_count !== EW'(want) || pass_at_done !== (want == 0) ||
        st_pass !== (want == 0)) begin
      bad++;
      $display("FAIL %s_res: err=%0d pass=%b/%b want %0d %b",
               nm, err_count, pass_at_done, st_pass, want, want == 0);
    end
    fault_inj = 1'b0;
  endtask

  task automatic test_selftest();
    run_sweep(1'b0, "st_clean");
    run_sweep(1'b1, "st_fault");
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (err_count !== 16'd16384) begin
      bad++;
      $display("FAIL st_hold: err=%0d want 16384", err_count);
    end
  endtask

  task automatic test_fault_normal();
    res_t r;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    fault_inj = 1'b1;
    op = 3'd2; a = W'($urandom); b = W'($urandom); c = W'($urandom);
    r = model(2, a, b, c, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (mis !== 1'b1 || e[0] !== ~d[0] || d !== r.d || e !== r.e) begin
      bad++;
      $display("FAIL fault_op2: d=%h e=%h mis=%b want %h %h 1",
               d, e, mis, r.d, r.e);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep_abort();
    int done_n;
    done_n = 0;
    @(negedge clk);
    st_start = 1'b1;
    @(negedge clk);
    st_start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (st_busy || st_done) done_n++;
      @(negedge clk);
    end
    total++;
    if (done_n != 0 || err_count !== '0) begin
      bad++;
      $display("FAIL abort: busy/done cycles=%0d err=%0d want 0 0",
               done_n, err_count);
    end
    run_sweep(1'b0, "st_after_abort");
  endtask

  task automatic test_start_blocked();
    int busy_n;
    busy_n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    st_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (st_busy) busy_n++;
      @(negedge clk);
    end
    st_start = 1'b0;
    total++;
    if (busy_n != 0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL start_blocked: busy=%0d ov=%b want 0 1",
               busy_n, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_op0_directed();
    test_backpressure();
    test_random();
    test_fault_normal();
    test_selftest();
    test_sweep_abort();
    test_start_blocked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bool_dual_eval.md
Name: bool_dual_eval

Overview:
- Parametrised successor to the lab's two-form boolean evaluator (D = (~A|~B)&~C vs E = ~((A&B)|C)).
- Evaluates W-bit bitwise functions of a, b, c two ways (direct form and De Morgan dual form). Results are registered behind a valid/ready handshake, with a per-result mismatch flag.
- Built-in exhaustive self-test FSM sweeps every op/input combination and counts form mismatches.
- Sits between lab switch/button inputs and LED/7-seg display logic.

Parameters:
- WIDTH, 4, bit width of a/b/c/d/e; legal range 1..4, so the sweep count fits in ERR_W.
- ERR_W, 16, width of the saturating mismatch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand handshake valid.
- in_ready  output  1  block accepts operands this cycle.
- op  input  3  function select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- fault_inj  input  1  invert bit 0 of dual-form result (test hook).
- out_valid  output  1  d/e/mis valid.
- out_ready  input  1  downstream accepts result.
- d  output  WIDTH  direct-form result.
- e  output  WIDTH  dual-form result.
- mis  output  1  |(d ^ e) for the held result.
- st_start  input  1  self-test request.
- st_busy  output  1  sweep in progress.
- st_done  output  1  one-cycle pulse at sweep end.
- st_pass  output  1  last sweep had zero mismatches; held until next start/reset.
- err_count  output  ERR_W  mismatches in the last or current sweep.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: all outputs 0 except in_ready, which is 1. FSM goes to IDLE. Reset mid-sweep aborts the sweep with no st_done pulse.
- Op encodings (d = direct form, e = dual form, bitwise):
  - op0: d = (~a|~b)&~c; e = ~((a&b)|c).
  - op1: d = (~a&~b)|c; e = ~((a|b)&~c).
  - op2: d = a^b^c; e = ~(~a^b^c).
  - op3: d = (a&b)|(a&c)|(b&c); e = ~((~a|~b)&(~a|~c)&(~b|~c)).
  - op4..7 (reserved): d = e = 0.
- fault_inj: when 1, e[0] is inverted after evaluation, in all ops and both modes.
- Normal mode (FSM IDLE):
  - in_ready = ~out_valid | out_ready.
  - Transfer occurs when in_valid & in_ready. d/e/mis register the evaluated operands, and out_valid=1 on the next cycle (latency 1).
  - Result is held stable while out_valid & ~out_ready.
  - Simultaneous output accept and new input: new result loaded, out_valid stays 1 (full throughput).
  - out_valid clears on out_ready when there is no new transfer.
- Self-test FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on st_start=1 when out_valid=0. st_start is ignored otherwise and in other states.
  - On entry to SWEEP: err_count cleared, st_pass cleared, vector counter cleared.
  - SWEEP:
    - st_busy=1, in_ready=0. External a/b/c/op are ignored; fault_inj is still honoured.
    - Vector counter of 2+3*WIDTH bits, split as {op[1:0], a, b, c}, c in the LSBs.
    - One vector per cycle, evaluated combinationally. If d != e, err_count increments, saturating at all-ones.
    - After the all-ones vector is evaluated -> DONE. Sweep length is 4*2^(3*WIDTH) cycles (16384 at WIDTH=4).
  - DONE (one cycle): st_done=1, st_pass=(err_count==0), then -> IDLE.
  - d/e/out_valid are not driven by the sweep; the normal-mode result register is untouched.
- err_count holds its value after DONE until the next sweep start or reset.

Decomposition:
- Shared package bool_pkg:
  - op encodings OP_NAND_NC=0, OP_NOR_OC=1, OP_XOR3=2, OP_MAJ=3.
  - FSM state typedef {ST_IDLE, ST_SWEEP, ST_DONE}.
  - ERR_W default.
- One combinational sub-module, bool_dual_core (op, a, b, c, fault_inj -> d, e).
  - Instantiated twice: once on the external operands (normal path) and once on the sweep counter fields.
  - Alternatively instantiated once behind a mux; either is acceptable.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic -> out_valid=0, in_ready=1, err_count=0, st_pass=0, d=e=0.
- op0 directed: a=4'b1100, b=4'b1010, c=4'b0001, in_valid=1, out_ready=1 -> next cycle d=e=4'b0110, mis=0, out_valid=1.
- Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0, d/e stable. Release with a new in_valid -> back-to-back results, no gap, no loss.
- Self-test clean, WIDTH=4: pulse st_start -> st_busy high 16384 cycles, st_done single pulse, st_pass=1, err_count=0.
- Self-test with fault_inj=1 -> err_count=16384 (all ops mismatch on bit 0), st_pass=0. Also normal op2 transfer -> mis=1, e[0]=~d[0].
- Reset mid-sweep at cycle 100 -> st_busy=0, no st_done pulse. A new st_start afterwards completes normally. st_start while out_valid=1 -> ignored, st_busy stays 0.
